vector_execute_unit: RTL

VECTOR_EXECUTE_UNIT -- requirements
Module: vector_execute_unit

---
 rtl/vector_execute_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/vector_execute_unit.sv
// Scalar/vector ALU execute stage: scalar ops finish in one cycle, vector ops
// sweep the lanes P at a time through a chunk counter before the done pulse.
module vector_execute_unit #(
  parameter int unsigned N = 32,
  parameter int unsigned L = 8,
  parameter int unsigned V = 20,
  parameter int unsigned P = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start_i,
  input  logic [1:0]       OpType_i,
  input  logic [1:0]       ALUControl_i,
  input  logic             ALUSource_i,
  input  logic             SetFlags_i,
  input  logic [N-1:0]     RD1_S_i,
  input  logic [N-1:0]     RD2_S_i,
  input  logic [N-1:0]     Extend_i,
  input  logic [V*L-1:0]   RD1_V_i,
  input  logic [V*L-1:0]   RD2_V_i,
  output logic [N-1:0]     ALUResult_S_o,
  output logic [V*L-1:0]   ALUResult_V_o,
  output logic [3:0]       Flags_o,
  output logic             busy_o,
  output logic             Exe_Finished_o
);

  localparam int unsigned CHUNKS = V / P;
  localparam int unsigned KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned CW     = P * L;
  localparam int unsigned VW     = V * L;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_SCALAR = 2'b00;
  localparam logic [1:0] OP_VV     = 2'b01;
  localparam logic [1:0] OP_VS     = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q;
  logic [1:0]    ctrl_q;
  logic [VW-1:0] a_v_q, b_v_q;

  logic [N-1:0]  b_s;
  logic [N:0]    add_w, sub_w;
  logic [N-1:0]  s_res;
  logic          s_c, s_v;
  logic [3:0]    s_flags;
  logic          is_vec;

  logic [CW-1:0] a_chunk, b_chunk, chunk_res;

  function automatic logic [L-1:0] lane_op(input logic [L-1:0] a, input logic [L-1:0] b,
                                           input logic [1:0] op);
    case (op)
      2'b00:   lane_op = a + b;
      2'b01:   lane_op = a - b;
      2'b10:   lane_op = a & b;
      default: lane_op = a | b;
    endcase
  endfunction

  // Scalar ALU operates straight off the inputs; its result is captured at the accept edge
  always_comb begin
    b_s   = ALUSource_i ? Extend_i : RD2_S_i;
    add_w = {1'b0, RD1_S_i} + {1'b0, b_s};
    sub_w = {1'b0, RD1_S_i} + {1'b0, ~b_s} + (N+1)'(1);
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    case (ALUControl_i)
      2'b00: begin
        s_res = add_w[N-1:0];
        s_c   = add_w[N];
        s_v   = (RD1_S_i[N-1] == b_s[N-1]) && (add_w[N-1] != RD1_S_i[N-1]);
      end
      2'b01: begin
        s_res = sub_w[N-1:0];
        s_c   = sub_w[N];
        s_v   = (RD1_S_i[N-1] != b_s[N-1]) && (sub_w[N-1] != RD1_S_i[N-1]);
      end
      2'b10:   s_res = RD1_S_i & b_s;
      default: s_res = RD1_S_i | b_s;
    endcase
    s_flags = {s_res[N-1], (s_res == '0), s_c, s_v};
    is_vec  = (OpType_i == OP_VV) || (OpType_i == OP_VS);
  end

  // Select the current chunk of latched operands and run P lane ALUs on it
  always_comb begin
    a_chunk   = '0;
    b_chunk   = '0;
    chunk_res = '0;
    for (int c = 0; c < int'(CHUNKS); c++) begin
      if (k_q == KW'(c)) begin
        a_chunk = a_v_q[c*CW +: CW];
        b_chunk = b_v_q[c*CW +: CW];
      end
    end
    for (int j = 0; j < int'(P); j++) begin
      chunk_res[j*L +: L] = lane_op(a_chunk[j*L +: L], b_chunk[j*L +: L], ctrl_q);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = is_vec ? BUSY : DONE;
      BUSY:    if (k_q == KW'(CHUNKS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers; status outputs track the next state so they are registered
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      k_q            <= '0;
      ctrl_q         <= '0;
      a_v_q          <= '0;
      b_v_q          <= '0;
      ALUResult_S_o  <= '0;
      ALUResult_V_o  <= '0;
      Flags_o        <= '0;
      busy_o         <= 1'b0;
      Exe_Finished_o <= 1'b0;
    end else begin
      busy_o         <= (state_d != IDLE);
      Exe_Finished_o <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (start_i) begin
            k_q    <= '0;
            ctrl_q <= ALUControl_i;
            a_v_q  <= RD1_V_i;
            b_v_q  <= (OpType_i == OP_VS) ? {V{b_s[L-1:0]}} : RD2_V_i;
            if (OpType_i == OP_SCALAR) begin
              ALUResult_S_o <= s_res;
              if (SetFlags_i) Flags_o <= s_flags;
            end else if (OpType_i == OP_NOP) begin
              ALUResult_S_o <= '0;
            end
          end
        end
        BUSY: begin
          for (int c = 0; c < int'(CHUNKS); c++) begin
            if (k_q == KW'(c)) ALUResult_V_o[c*CW +: CW] <= chunk_res;
          end
          k_q <= k_q + KW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
